// File: rtl/gpio_in_filter.sv
// gpio_in_filter: per-pin synchronizer + debounce ahead of the gpio input path.
// Ports: clk, rst (sync, active-high); pad_i raw pads; filt_en_i per-pin
// debounce enable (0 = bypass); db_limit_i stable cycles needed to accept;
// pins_o filtered levels; rise_o/fall_o one-cycle accepted-edge pulses.
// Build option: define GPIO_FILT_EDGE_EN to build the edge-pulse flops;
// otherwise rise_o/fall_o are tied to 0 (ports kept).
module gpio_in_filter #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pad_i,
  input  logic [WIDTH-1:0] filt_en_i,
  input  logic [CNT_W-1:0] db_limit_i,
  output logic [WIDTH-1:0] pins_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] stable_q;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W:0]   cnt_inc [WIDTH];
  logic [WIDTH-1:0] differ;
  logic [WIDTH-1:0] reached;
  logic [WIDTH-1:0] accept;

  // pad_i feeds nothing but the first synchronizer stage
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_q[s] <= '0;
      end
    end else begin
      sync_q[0] <= pad_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  // Compare is done one bit wider so cnt+1 never wraps; limit 0 and
  // limit 1 both accept on the first differing cycle.
  always_comb begin
    differ  = sync ^ stable_q;
    reached = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_inc[i] = {1'b0, cnt_q[i]} + (CNT_W+1)'(1);
      reached[i] = cnt_inc[i] >= {1'b0, db_limit_i};
    end
    accept = differ & (~filt_en_i | reached);
  end

  // Any cycle where sync matches the stable level clears the count,
  // so a single-cycle glitch restarts debouncing from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_q ^ accept;
      for (int i = 0; i < WIDTH; i++) begin
        if (differ[i] && !accept[i]) begin
          cnt_q[i] <= cnt_inc[i][CNT_W-1:0];
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  assign pins_o = stable_q;

`ifdef GPIO_FILT_EDGE_EN
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;

  // Pulses register on the same edge that flips the stable level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= accept & sync;
      fall_q <= accept & ~sync;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;
`else
  assign rise_o = '0;
  assign fall_o = '0;
`endif

endmodule
